serial_controller: RTL and testbench
====================================

SERIAL_CONTROLLER -- requirements
Module: serial_controller

Interface
REQ-001 SHALL have parameter CLK_DIV, default 512, meaning clock cycles per internal serial bit; must be even and at least 4; 512 gives 8192 Hz at 4.194304 MHz.
REQ-002 SHALL have port clock, input, 1, system clock; all logic on its rising edge.
REQ-003 SHALL have port reset_n, input, 1; reset is synchronous and active-low.
REQ-004 SHALL have port A, input, 16, CPU/MMU address.
REQ-005 SHALL have port Di, input, 8, write data from CPU.
REQ-006 SHALL have port Do, output, 8, read data to MMU.
REQ-007 SHALL have port cs, input, 1, MMU select for the FF01-FF02 range.
REQ-008 SHALL have port rd_n, input, 1, active-low read strobe.
REQ-009 SHALL have port wr_n, input, 1, active-low write strobe.
REQ-010 SHALL have port int_req, output, 1, serial interrupt request, driven to interrupt controller bit 3.
REQ-011 SHALL have port int_ack, input, 1, serial interrupt acknowledge from the interrupt controller.
REQ-012 SHALL have port serial_out, output, 1, link data out.
REQ-013 SHALL have port serial_in, input, 1, link data in (asynchronous).
REQ-014 SHALL have port serial_clk_out, output, 1, link clock in internal mode.
REQ-015 SHALL have port serial_clk_in, input, 1, link clock in external mode (asynchronous).

Function
REQ-016 SHALL decode SB at A=FF01 and SC at A=FF02, but only when cs=1.
REQ-017 Register write SHALL occur on any clock with cs=1 and wr_n=0; one write per cycle.
REQ-018 Do SHALL be combinational.
- cs=1, rd_n=0, A=FF01: Do = SB.
- cs=1, rd_n=0, A=FF02: Do = {SC[7], 6'b111111, SC[0]}.
- Otherwise: Do = 8'h00.
REQ-019 SC[7] is the start/busy flag; SC[0]=1 selects internal clock, 0 selects external clock.
REQ-020 The FSM SHALL use three states:
- IDLE
- LOW: link clock low; waiting for the rising edge.
- HIGH: link clock high; waiting for the falling edge, or done.
REQ-021 IDLE->LOW on an SC write with Di[7]=1:
- bit counter cleared to 0;
- serial_out <= SB[7] on the next cycle;
- in internal mode, serial_clk_out <= 0 on the next cycle.
REQ-022 Internal mode, LOW: after CLK_DIV/2 cycles:
- serial_clk_out <= 1;
- SB <= {SB[6:0], serial_in_sync};
- counter increments;
- state -> HIGH.
REQ-023 Internal mode, HIGH: after CLK_DIV/2 cycles:
- if counter=8, -> IDLE;
- else serial_clk_out <= 0, serial_out <= SB[7], state -> LOW.
REQ-024 Internal mode timing: start written at cycle t completes at cycle t+1+8*CLK_DIV-CLK_DIV/2, i.e. the 8th rising edge. On that cycle:
- SC[7] <= 0;
- int_req <= 1;
- state -> IDLE;
- serial_clk_out SHALL return to 1.
REQ-025 External mode SHALL pass serial_clk_in and serial_in through 2-flop synchronizers.
- Synchronized rising edge: sample/shift as in REQ-022.
- Synchronized falling edge: serial_out <= SB[7].
- Completion as in REQ-024 on the 8th rising edge.
- No timeout.
REQ-026 serial_clk_out SHALL stay 1 throughout external mode and IDLE.
REQ-027 An SB write while SC[7]=1 SHALL be ignored.
REQ-028 An SC write with Di[7]=0 during a transfer SHALL abort:
- state -> IDLE, counter -> 0;
- SB keeps its partially shifted value;
- no int_req;
- serial_clk_out -> 1.
REQ-029 An SC write with Di[7]=1 during a transfer SHALL update SC[0] only; it does not restart the transfer.
REQ-030 int_req SHALL stay high until an int_ack=1 cycle clears it. If completion and int_ack occur in the same cycle, set wins.
REQ-031 serial_out SHALL hold its last driven value while IDLE.

Reset
REQ-032 On reset_n=0 at a clock edge, the block SHALL load:
- SB=8'h00, SC[7]=0, SC[0]=0;
- state=IDLE, counter=0, divider=0;
- int_req=0, serial_out=1, serial_clk_out=1;
- synchronizers=1.
REQ-033 Reset mid-transfer SHALL abort immediately with the REQ-032 values and no int_req.

Verification (CLK_DIV=4 unless noted)
REQ-034 Write SB=A5, SC=81 at t, with serial_in tied to 1:
- serial_out shows 1,0,1,0,0,1,0,1, changing every 4 cycles from t+1;
- int_req rises at t+31;
- SB reads FF, SC reads 7F.
REQ-035 Write SB=3C, SC=80 (external mode), drive serial_in=0 and 8 slow external clock pulses (period 20 cycles):
- int_req is set only after the 8th rising edge plus 2-3 sync cycles;
- SB=00;
- serial_clk_out stays 1.
REQ-036 Start an internal transfer of SB=F0 with serial_in=0, then write SC=01 after 2 rising edges:
- state returns to IDLE with SB=C0;
- int_req stays 0;
- SC reads 7F.
REQ-037 Write SB=55 mid-transfer: it is ignored and the shift continues. Pulse int_ack on the completion cycle: int_req=1 remains, and the next int_ack clears it.
REQ-038 Assert reset_n=0 for one cycle at the 4th bit:
- all outputs match REQ-032;
- a subsequent SC=81 start runs a full 8-bit transfer.
REQ-039 Read with cs=0 at A=FF01 gives Do=00. With CLK_DIV=512, a full internal transfer completes in 3841 cycles.

Source files
------------

// File: rtl/serial_controller.sv
// Link-port serial controller: SB shift register and SC control register at FF01/FF02.
// Eight-bit transfers in either direction, clocked internally (CLK_DIV) or by the peer.
module serial_controller #(
  parameter int unsigned CLK_DIV = 512  // must be even and >= 4
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [15:0] A,
  input  logic [7:0]  Di,
  output logic [7:0]  Do,
  input  logic        cs,
  input  logic        rd_n,
  input  logic        wr_n,
  output logic        int_req,
  input  logic        int_ack,
  output logic        serial_out,
  input  logic        serial_in,
  output logic        serial_clk_out,
  input  logic        serial_clk_in
);

  localparam int unsigned HalfDiv = CLK_DIV / 2;
  localparam int unsigned DivW    = $clog2(HalfDiv + 1);
  localparam logic [DivW-1:0] DivLoad = DivW'(HalfDiv);
  localparam logic [DivW-1:0] DivHalf = DivW'(HalfDiv - 1);

  typedef enum logic [1:0] {
    StIdle,
    StLow,
    StHigh
  } state_e;

  state_e          state_q, state_d;
  logic [7:0]      sb_q, sb_d;
  logic            busy_q, busy_d;
  logic            int_sel_q, int_sel_d;
  logic [3:0]      bit_cnt_q, bit_cnt_d;
  logic [DivW-1:0] div_q, div_d;
  logic            int_req_q, int_req_d;
  logic            sout_q, sout_d;
  logic            sclk_out_q, sclk_out_d;
  logic            launch_q, launch_d;
  logic [1:0]      sin_sync_q;
  logic [1:0]      sclk_sync_q;
  logic            sclk_prev_q;

  logic wr_en, sb_hit, sc_hit;
  logic div_done, sclk_rise, sclk_fall, rise_evt, fall_evt, complete;

  assign sb_hit    = cs && (A == 16'hFF01);
  assign sc_hit    = cs && (A == 16'hFF02);
  assign wr_en     = cs && !wr_n;
  assign div_done  = (div_q == '0);
  assign sclk_rise = sclk_sync_q[1] && !sclk_prev_q;
  assign sclk_fall = !sclk_sync_q[1] && sclk_prev_q;
  assign rise_evt  = int_sel_q ? div_done : sclk_rise;
  assign fall_evt  = int_sel_q ? div_done : sclk_fall;

  always_comb begin
    Do = 8'h00;
    if (cs && !rd_n) begin
      if (A == 16'hFF01) begin
        Do = sb_q;
      end else if (A == 16'hFF02) begin
        Do = {busy_q, 6'b111111, int_sel_q};
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    sb_d       = sb_q;
    busy_d     = busy_q;
    int_sel_d  = int_sel_q;
    bit_cnt_d  = bit_cnt_q;
    div_d      = div_q;
    int_req_d  = int_req_q;
    sout_d     = sout_q;
    sclk_out_d = sclk_out_q;
    launch_d   = 1'b0;
    complete   = 1'b0;

    // First bit goes out one cycle after the start write.
    if (launch_q) begin
      sout_d     = sb_q[7];
      sclk_out_d = 1'b0;
    end

    unique case (state_q)
      StLow: begin
        if (rise_evt) begin
          sb_d       = {sb_q[6:0], sin_sync_q[1]};
          bit_cnt_d  = bit_cnt_q + 4'd1;
          div_d      = DivHalf;
          sclk_out_d = 1'b1;
          if (bit_cnt_q == 4'd7) begin
            complete = 1'b1;
            state_d  = StIdle;
            busy_d   = 1'b0;
          end else begin
            state_d = StHigh;
          end
        end else if (!div_done) begin
          div_d = div_q - 1'b1;
        end
      end
      StHigh: begin
        if (fall_evt) begin
          sout_d     = sb_q[7];
          sclk_out_d = 1'b0;
          div_d      = DivHalf;
          state_d    = StLow;
        end else if (!div_done) begin
          div_d = div_q - 1'b1;
        end
      end
      default: ;
    endcase

    if (wr_en && sb_hit && !busy_q) begin
      sb_d = Di;
    end

    if (wr_en && sc_hit) begin
      int_sel_d = Di[0];
      if (state_q == StIdle) begin
        if (Di[7]) begin
          state_d   = StLow;
          busy_d    = 1'b1;
          bit_cnt_d = 4'd0;
          div_d     = DivLoad;
          launch_d  = 1'b1;
        end
      end else if (!Di[7]) begin
        // Abort keeps the partially shifted SB and raises no interrupt.
        state_d   = StIdle;
        busy_d    = 1'b0;
        bit_cnt_d = 4'd0;
        complete  = 1'b0;
      end
    end

    if (!int_sel_d || (state_d == StIdle)) begin
      sclk_out_d = 1'b1;
    end

    if (complete) begin
      int_req_d = 1'b1;
    end else if (int_ack) begin
      int_req_d = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      sb_q        <= 8'h00;
      busy_q      <= 1'b0;
      int_sel_q   <= 1'b0;
      bit_cnt_q   <= 4'd0;
      div_q       <= '0;
      int_req_q   <= 1'b0;
      sout_q      <= 1'b1;
      sclk_out_q  <= 1'b1;
      launch_q    <= 1'b0;
      sin_sync_q  <= 2'b11;
      sclk_sync_q <= 2'b11;
      sclk_prev_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      sb_q        <= sb_d;
      busy_q      <= busy_d;
      int_sel_q   <= int_sel_d;
      bit_cnt_q   <= bit_cnt_d;
      div_q       <= div_d;
      int_req_q   <= int_req_d;
      sout_q      <= sout_d;
      sclk_out_q  <= sclk_out_d;
      launch_q    <= launch_d;
      sin_sync_q  <= {sin_sync_q[0], serial_in};
      sclk_sync_q <= {sclk_sync_q[0], serial_clk_in};
      sclk_prev_q <= sclk_sync_q[1];
    end
  end

  assign int_req        = int_req_q;
  assign serial_out     = sout_q;
  assign serial_clk_out = sclk_out_q;

endmodule

// File: tb/tb_serial_controller.sv
// Directed bench for serial_controller: register decode table plus transfer sequences.
module tb_serial_controller;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic [15:0] A = 16'h0000;
  logic [7:0]  Di = 8'h00;
  logic [7:0]  Do;
  logic        cs = 1'b0, rd_n = 1'b1, wr_n = 1'b1;
  logic        int_req, int_ack = 1'b0;
  logic        serial_out, serial_in = 1'b1;
  logic        serial_clk_out, serial_clk_in = 1'b1;

  logic [15:0] A2 = 16'h0000;
  logic [7:0]  Di2 = 8'h00;
  logic [7:0]  Do2;
  logic        cs2 = 1'b0, wr_n2 = 1'b1;
  logic        int_req2, so2, sco2;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  serial_controller #(.CLK_DIV(4)) u_dut (
    .clock(clock), .reset_n(reset_n), .A(A), .Di(Di), .Do(Do), .cs(cs), .rd_n(rd_n),
    .wr_n(wr_n), .int_req(int_req), .int_ack(int_ack), .serial_out(serial_out),
    .serial_in(serial_in), .serial_clk_out(serial_clk_out), .serial_clk_in(serial_clk_in)
  );

  serial_controller #(.CLK_DIV(512)) u_dut512 (
    .clock(clock), .reset_n(reset_n), .A(A2), .Di(Di2), .Do(Do2), .cs(cs2), .rd_n(1'b1),
    .wr_n(wr_n2), .int_req(int_req2), .int_ack(1'b0), .serial_out(so2),
    .serial_in(1'b1), .serial_clk_out(sco2), .serial_clk_in(1'b1)
  );

  typedef struct {
    logic [15:0] wa;
    logic [7:0]  wd;
    logic        wcs;
    logic [15:0] ra;
    logic        rcs;
    logic        rrd_n;
    logic [7:0]  exp;
    string       name;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string nm, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h (t=%0t)", nm, got, exp, $time);
    end
  endtask

  task automatic wr(input logic [15:0] a, input logic [7:0] d);
    @(negedge clock);
    A = a; Di = d; cs = 1'b1; wr_n = 1'b0;
    @(posedge clock);
    #1;
    cs = 1'b0; wr_n = 1'b1;
  endtask

  task automatic rd(input logic [15:0] a, input logic c, input logic r, output logic [7:0] d);
    A = a; cs = c; rd_n = r;
    #1;
    d = Do;
    cs = 1'b0; rd_n = 1'b1;
  endtask

  task automatic rdchk(input string nm, input logic [15:0] a, input logic [7:0] exp);
    logic [7:0] d;
    rd(a, 1'b1, 1'b0, d);
    chk(nm, {8'h00, d}, {8'h00, exp});
  endtask

  task automatic wait_cyc(input int target);
    while (cyc < target) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic ack(input string nm);
    @(negedge clock);
    int_ack = 1'b1;
    @(posedge clock);
    #1;
    int_ack = 1'b0;
    chk(nm, {15'd0, int_req}, 16'd0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] d;
    logic [7:0] pat;
    int t;
    int k;

    vecs[0] = '{16'hFF01, 8'hAA, 1'b0, 16'hFF01, 1'b1, 1'b0, 8'h00, "cs0_write_ignored"};
    vecs[1] = '{16'hFF01, 8'h5A, 1'b1, 16'hFF01, 1'b1, 1'b0, 8'h5A, "sb_write_read"};
    vecs[2] = '{16'hFF02, 8'h01, 1'b1, 16'hFF02, 1'b1, 1'b0, 8'h7F, "sc_int_sel"};
    vecs[3] = '{16'hFF02, 8'h00, 1'b1, 16'hFF02, 1'b1, 1'b0, 8'h7E, "sc_ext_sel"};
    vecs[4] = '{16'hFF03, 8'h33, 1'b1, 16'hFF01, 1'b1, 1'b0, 8'h5A, "unmapped_write"};
    vecs[5] = '{16'hFF01, 8'h00, 1'b0, 16'hFF01, 1'b0, 1'b0, 8'h00, "read_cs0"};
    vecs[6] = '{16'hFF01, 8'h00, 1'b0, 16'hFF01, 1'b1, 1'b1, 8'h00, "read_rdn_high"};
    vecs[7] = '{16'hFF01, 8'hC3, 1'b1, 16'hFF02, 1'b1, 1'b0, 8'h7E, "sb_write_sc_read"};
    vecs[8] = '{16'hFF01, 8'h00, 1'b0, 16'hFF00, 1'b1, 1'b0, 8'h00, "read_unmapped"};

    repeat (3) @(posedge clock);
    #1;
    reset_n = 1'b1;

    // Reset state
    chk("rst_int_req", {15'd0, int_req}, 16'd0);
    chk("rst_serial_out", {15'd0, serial_out}, 16'd1);
    chk("rst_sclk_out", {15'd0, serial_clk_out}, 16'd1);
    rdchk("rst_sb", 16'hFF01, 8'h00);
    rdchk("rst_sc", 16'hFF02, 8'h7E);

    // Register decode table
    for (int i = 0; i < 9; i++) begin
      if (vecs[i].wcs) wr(vecs[i].wa, vecs[i].wd);
      else @(negedge clock);
      rd(vecs[i].ra, vecs[i].rcs, vecs[i].rrd_n, d);
      chk(vecs[i].name, {8'h00, d}, {8'h00, vecs[i].exp});
    end

    // Internal transfer of A5 with serial_in high
    serial_in = 1'b1;
    pat = 8'hA5;
    wr(16'hFF01, 8'hA5);
    wr(16'hFF02, 8'h81);
    for (int m = 1; m <= 33; m++) begin
      @(negedge clock);
      if (m >= 2) chk($sformatf("so_m%0d", m), {15'd0, serial_out}, {15'd0, pat[7-(m-2)/4]});
      chk($sformatf("sclk_m%0d", m), {15'd0, serial_clk_out},
          (m == 1) ? 16'd1 : (((m - 2) % 4 >= 2) ? 16'd1 : 16'd0));
      chk($sformatf("irq_m%0d", m), {15'd0, int_req}, (m >= 32) ? 16'd1 : 16'd0);
    end
    rdchk("a5_sb_final", 16'hFF01, 8'hFF);
    rdchk("a5_sc_final", 16'hFF02, 8'h7F);
    ack("a5_ack_clears");

    // SB write ignored while busy; ack on completion cycle loses to set
    serial_in = 1'b0;
    wr(16'hFF01, 8'h81);
    wr(16'hFF02, 8'h81);
    t = cyc;
    wait_cyc(t + 10);
    wr(16'hFF01, 8'h55);
    wait_cyc(t + 30);
    chk("ack_pre_irq", {15'd0, int_req}, 16'd0);
    int_ack = 1'b1;
    @(posedge clock);
    #1;
    int_ack = 1'b0;
    chk("ack_same_cycle_set_wins", {15'd0, int_req}, 16'd1);
    rdchk("busy_sb_write_ignored", 16'hFF01, 8'h00);
    ack("ack_next_clears");

    // Abort after two rising edges
    wr(16'hFF01, 8'hF0);
    wr(16'hFF02, 8'h81);
    t = cyc;
    wait_cyc(t + 8);
    wr(16'hFF02, 8'h01);
    rdchk("abort_sb", 16'hFF01, 8'hC0);
    rdchk("abort_sc", 16'hFF02, 8'h7F);
    chk("abort_sclk", {15'd0, serial_clk_out}, 16'd1);
    wait_cyc(cyc + 40);
    chk("abort_no_irq", {15'd0, int_req}, 16'd0);
    rdchk("abort_sb_held", 16'hFF01, 8'hC0);

    // External clock transfer
    serial_in = 1'b0;
    serial_clk_in = 1'b1;
    wr(16'hFF01, 8'h3C);
    wr(16'hFF02, 8'h80);
    for (int p = 0; p < 8; p++) begin
      @(negedge clock);
      serial_clk_in = 1'b0;
      repeat (10) @(negedge clock);
      chk($sformatf("ext_sclk_p%0d", p), {15'd0, serial_clk_out}, 16'd1);
      serial_clk_in = 1'b1;
      if (p < 7) begin
        repeat (10) @(negedge clock);
        chk($sformatf("ext_noirq_p%0d", p), {15'd0, int_req}, 16'd0);
      end
    end
    @(posedge clock);
    #1;
    chk("ext_irq_not_immediate", {15'd0, int_req}, 16'd0);
    k = 1;
    while (!int_req && k < 8) begin
      @(posedge clock);
      #1;
      k++;
    end
    chk("ext_irq_latency_2to3", {15'd0, (int_req && k >= 2 && k <= 3)}, 16'd1);
    rdchk("ext_sb", 16'hFF01, 8'h00);
    rdchk("ext_sc", 16'hFF02, 8'h7E);
    chk("ext_sclk_end", {15'd0, serial_clk_out}, 16'd1);
    ack("ext_ack");

    // Reset mid-transfer, then a full restart
    serial_in = 1'b1;
    wr(16'hFF01, 8'hA5);
    wr(16'hFF02, 8'h81);
    t = cyc;
    wait_cyc(t + 14);
    @(negedge clock);
    reset_n = 1'b0;
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    chk("mrst_serial_out", {15'd0, serial_out}, 16'd1);
    chk("mrst_sclk_out", {15'd0, serial_clk_out}, 16'd1);
    chk("mrst_int_req", {15'd0, int_req}, 16'd0);
    rdchk("mrst_sb", 16'hFF01, 8'h00);
    rdchk("mrst_sc", 16'hFF02, 8'h7E);
    wait_cyc(cyc + 40);
    chk("mrst_no_irq_later", {15'd0, int_req}, 16'd0);
    wr(16'hFF02, 8'h81);
    t = cyc;
    wait_cyc(t + 30);
    chk("restart_irq_early", {15'd0, int_req}, 16'd0);
    wait_cyc(t + 31);
    chk("restart_irq", {15'd0, int_req}, 16'd1);
    rdchk("restart_sb", 16'hFF01, 8'hFF);
    ack("restart_ack");

    // Full-rate divider: 3841 cycles from start write to completion
    @(negedge clock);
    A2 = 16'hFF02; Di2 = 8'h81; cs2 = 1'b1; wr_n2 = 1'b0;
    @(posedge clock);
    #1;
    cs2 = 1'b0; wr_n2 = 1'b1;
    t = cyc;
    wait_cyc(t + 3840);
    chk("div512_irq_early", {15'd0, int_req2}, 16'd0);
    wait_cyc(t + 3841);
    chk("div512_irq", {15'd0, int_req2}, 16'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
